ppi_read_ctrl: RTL

Read-side controller for the 8255A-style parallel port. It sequences CPU read cycles and drives the select code and output enable for the data-out multiplexer. It implements the mode-1 strobed-input handshake for ports A and B: input buffers, IBF and INTR flags. It also assembles the port C status byte that the multiplexer returns on port C reads.

---
 rtl/ppi_read_ctrl_if.sv | 40 ++++
 rtl/ppi_read_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_read_ctrl_if.sv
// Bus bundle for the 8255A-style read-side controller.
// Holds the CPU read strobe/address, port input pins, strobes and all
// handshake, buffer and multiplexer-control outputs. The slave modport is
// the controller's view; the master modport is the driving environment.
interface ppi_read_ctrl_if;
    logic       cs_n;
    logic       rd_n;
    logic [1:0] a;
    logic       mode_a;
    logic       mode_b;
    logic       inte_a;
    logic       inte_b;
    logic       stb_a_n;
    logic       stb_b_n;
    logic [7:0] pa_in;
    logic [7:0] pb_in;
    logic [7:0] pa_in_buf;
    logic [7:0] pb_in_buf;
    logic [3:0] dout_sel;
    logic       d_oe;
    logic       ibf_a;
    logic       ibf_b;
    logic       intr_a;
    logic       intr_b;
    logic [7:0] pc_status;

    modport master (
        output cs_n, rd_n, a, mode_a, mode_b, inte_a, inte_b,
               stb_a_n, stb_b_n, pa_in, pb_in,
        input  pa_in_buf, pb_in_buf, dout_sel, d_oe,
               ibf_a, ibf_b, intr_a, intr_b, pc_status
    );

    modport slave (
        input  cs_n, rd_n, a, mode_a, mode_b, inte_a, inte_b,
               stb_a_n, stb_b_n, pa_in, pb_in,
        output pa_in_buf, pb_in_buf, dout_sel, d_oe,
               ibf_a, ibf_b, intr_a, intr_b, pc_status
    );
endinterface

// File: rtl/ppi_read_ctrl.sv
// ppi_read_ctrl: read-side controller of an 8255A-style parallel port.
// Sequences CPU reads (IDLE -> ACTIVE -> DONE), drives the data-out
// multiplexer select code and bus enable, runs the mode-1 strobed-input
// handshake (buffer, IBF, INTR) for ports A and B and builds the port C
// status byte.
// Optional feature macro: PPI_PCSTATUS_EN enables the port C status byte
// and the a = 10 read path; when undefined pc_status is 8'h00 and a = 10
// reads like the unreadable control register.
module ppi_read_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst_n,
    ppi_read_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       ibf;
        logic       intr;
    } port_t;

    // Next handshake state of one port. Sets win over clears in the same
    // cycle so a strobe arriving with a read completion is never lost.
    function automatic port_t port_next(
        input port_t      cur,
        input logic       mode,
        input logic       inte,
        input logic       stb_fall,
        input logic       stb_rise,
        input logic       clr_ibf,
        input logic       clr_intr,
        input logic [7:0] pins
    );
        port_t nxt;
        nxt = cur;
        if (!mode) begin
            nxt.ibf  = 1'b0;
            nxt.intr = 1'b0;
        end else begin
            if (stb_fall) begin
                nxt.data = pins;
                nxt.ibf  = 1'b1;
            end else if (clr_ibf) begin
                nxt.ibf = 1'b0;
            end else begin
                nxt.ibf = cur.ibf;
            end
            if (stb_rise && cur.ibf && inte) begin
                nxt.intr = 1'b1;
            end else if (clr_intr || !inte) begin
                nxt.intr = 1'b0;
            end else begin
                nxt.intr = cur.intr;
            end
        end
        return nxt;
    endfunction

    // Bus enable and multiplexer select for a given FSM state and address.
    function automatic logic [4:0] read_out(
        input state_t     st,
        input logic [1:0] addr,
        input logic       ma,
        input logic       mb
    );
        logic [4:0] r;
        r = {1'b0, 4'b1111};
        if (st == ST_ACTIVE) begin
            case (addr)
                2'b00:   r = {1'b1, (ma ? 4'b0001 : 4'b0000)};
                2'b01:   r = {1'b1, (mb ? 4'b0011 : 4'b0010)};
`ifdef PPI_PCSTATUS_EN
                2'b10:   r = {1'b1, 4'b0100};
`else
                2'b10:   r = {1'b0, 4'b1111};
`endif
                default: r = {1'b0, 4'b1111};
            endcase
        end else begin
            r = {1'b0, 4'b1111};
        end
        return r;
    endfunction

    // Index 0 = rd_n, 1 = stb_a_n, 2 = stb_b_n.
    logic [2:0]             async_in_s;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [2:0]             prev_q;
    logic [2:0]             synced_s;
    logic [2:0]             fall_s;
    logic [2:0]             rise_s;

    state_t     state_q, state_d;
    logic [1:0] a_q, a_d;
    logic       read_start_s;
    logic       read_end_s;

    port_t      port_a_q, port_a_d;
    port_t      port_b_q, port_b_d;
    logic       clr_intr_a_s, clr_intr_b_s;
    logic       clr_ibf_a_s, clr_ibf_b_s;

    logic [3:0] dout_sel_q;
    logic       d_oe_q;
    logic [4:0] out_d;
    logic [7:0] pc_status_q, pc_status_d;

    assign async_in_s = {bus.stb_b_n, bus.stb_a_n, bus.rd_n};

    // Synchronizer chains and previous-value flops for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {SYNC_STAGES{1'b1}};
            end
            prev_q <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in_s[i]};
            end
            prev_q <= synced_s;
        end
    end

    // Synchronized levels and their falling/rising edge pulses.
    always_comb begin
        synced_s = 3'b111;
        for (int i = 0; i < 3; i++) begin
            synced_s[i] = sync_q[i][SYNC_STAGES-1];
        end
        fall_s = prev_q & ~synced_s;
        rise_s = ~prev_q & synced_s;
    end

    assign read_start_s = (state_q == ST_IDLE) && fall_s[0] && !bus.cs_n;
    assign read_end_s   = (state_q == ST_ACTIVE) && rise_s[0];

    // Read FSM next state; address is captured only when a read begins.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        case (state_q)
            ST_IDLE: begin
                if (read_start_s) begin
                    state_d = ST_ACTIVE;
                    a_d     = bus.a;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (rise_s[0]) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read FSM state and latched address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
        end
    end

    // Handshake clears: INTR on read entry, IBF on the step into DONE.
    assign clr_intr_a_s = read_start_s && (bus.a == 2'b00);
    assign clr_intr_b_s = read_start_s && (bus.a == 2'b01);
    assign clr_ibf_a_s  = read_end_s && (a_q == 2'b00);
    assign clr_ibf_b_s  = read_end_s && (a_q == 2'b01);

    // Next handshake state, mux controls and status byte.
    always_comb begin
        port_a_d = port_next(port_a_q, bus.mode_a, bus.inte_a, fall_s[1], rise_s[1],
                             clr_ibf_a_s, clr_intr_a_s, bus.pa_in);
        port_b_d = port_next(port_b_q, bus.mode_b, bus.inte_b, fall_s[2], rise_s[2],
                             clr_ibf_b_s, clr_intr_b_s, bus.pb_in);
        out_d    = read_out(state_d, a_d, bus.mode_a, bus.mode_b);
`ifdef PPI_PCSTATUS_EN
        pc_status_d = {2'b00, port_a_d.ibf, bus.inte_a, port_a_d.intr,
                       bus.inte_b, port_b_d.ibf, port_b_d.intr};
`else
        pc_status_d = 8'h00;
`endif
    end

    // Registered port state and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_a_q    <= '{data: 8'h00, ibf: 1'b0, intr: 1'b0};
            port_b_q    <= '{data: 8'h00, ibf: 1'b0, intr: 1'b0};
            d_oe_q      <= 1'b0;
            dout_sel_q  <= 4'b1111;
            pc_status_q <= 8'h00;
        end else begin
            port_a_q    <= port_a_d;
            port_b_q    <= port_b_d;
            d_oe_q      <= out_d[4];
            dout_sel_q  <= out_d[3:0];
            pc_status_q <= pc_status_d;
        end
    end

    assign bus.pa_in_buf = port_a_q.data;
    assign bus.pb_in_buf = port_b_q.data;
    assign bus.ibf_a     = port_a_q.ibf;
    assign bus.ibf_b     = port_b_q.ibf;
    assign bus.intr_a    = port_a_q.intr;
    assign bus.intr_b    = port_b_q.intr;
    assign bus.d_oe      = d_oe_q;
    assign bus.dout_sel  = dout_sel_q;
    assign bus.pc_status = pc_status_q;

endmodule
